// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor D = X - Y - borrowin, LSB first, one bit per clock.
// Result, borrowout and overflow are registered on the final-bit edge; done pulses for one cycle after it.
module serial_subtractor #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         borrowin,
  input  logic [n-1:0] X,
  input  logic [n-1:0] Y,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] D,
  output logic         borrowout,
  output logic         overflow
);

  localparam int CW = (n > 2) ? $clog2(n) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [n-1:0]   x_q;
  logic [n-1:0]   y_q;
  logic [n-1:0]   res_q;
  logic [CW-1:0]  cnt_q;
  logic           b_q;
  logic           xs_q;
  logic           ys_q;
  logic           busy_q;
  logic           done_q;
  logic [n-1:0]   d_q;
  logic           borrowout_q;
  logic           overflow_q;

  logic           diff_bit;
  logic           b_d;
  logic [n-1:0]   res_d;
  logic           last_bit;

  // One full-subtractor cell; the operand registers present bit i at position 0.
  always_comb begin
    diff_bit = x_q[0] ^ y_q[0] ^ b_q;
    b_d      = (~x_q[0] & y_q[0]) | (~x_q[0] & b_q) | (y_q[0] & b_q);
    res_d    = {diff_bit, res_q[n-1:1]};
    last_bit = (cnt_q == CW'(n - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      b_q         <= 1'b0;
      xs_q        <= 1'b0;
      ys_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      d_q         <= '0;
      borrowout_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= X;
            y_q     <= Y;
            b_q     <= borrowin;
            xs_q    <= X[n-1];
            ys_q    <= Y[n-1];
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          x_q   <= x_q >> 1;
          y_q   <= y_q >> 1;
          b_q   <= b_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            // The sign bits were captured at accept because the operand registers have shifted away.
            d_q         <= res_d;
            borrowout_q <= b_d;
            overflow_q  <= (xs_q ^ ys_q) & (diff_bit ^ xs_q);
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign D         = d_q;
  assign borrowout = borrowout_q;
  assign overflow  = overflow_q;

endmodule
